// File: rtl/refi_addr_sequencer.sv
// REFI address sequencer: issues a strided address stream with an optional
// initial delay, inter-address gaps and repeated passes from a moving base.
module refi_addr_sequencer #(
  parameter int ADDR_WIDTH  = 6,
  parameter int DELAY_WIDTH = 6,
  parameter int REP_WIDTH   = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_start,
  input  logic [ADDR_WIDTH-1:0]  start_addr,
  input  logic [ADDR_WIDTH-1:0]  no_of_addrs,
  input  logic [DELAY_WIDTH-1:0] initial_delay,
  input  logic [ADDR_WIDTH-1:0]  step_val,
  input  logic                   step_sign,
  input  logic [DELAY_WIDTH-1:0] middle_delay,
  input  logic [REP_WIDTH-1:0]   no_of_rpts,
  input  logic [ADDR_WIDTH-1:0]  rpt_step,
  input  logic                   abort,
  output logic [ADDR_WIDTH-1:0]  addr_out,
  output logic                   addr_en,
  output logic                   busy,
  output logic                   done,
  output logic                   start_err
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_INIT_DLY = 2'd1;
  localparam logic [1:0] S_ISSUE    = 2'd2;
  localparam logic [1:0] S_MID_DLY  = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [DELAY_WIDTH-1:0] dly_cnt_q, dly_cnt_d;
  logic [ADDR_WIDTH-1:0]  cur_addr_q, cur_addr_d;     // address issued next / now
  logic [ADDR_WIDTH-1:0]  base_q, base_d;             // base of current repetition
  logic [ADDR_WIDTH-1:0]  addr_out_q, addr_out_d;     // holds last issued address
  logic [ADDR_WIDTH-1:0]  addr_idx_q, addr_idx_d;
  logic [REP_WIDTH-1:0]   rpt_idx_q, rpt_idx_d;
  logic [ADDR_WIDTH-1:0]  no_of_addrs_q, no_of_addrs_d;
  logic [ADDR_WIDTH-1:0]  step_val_q, step_val_d;
  logic                   step_sign_q, step_sign_d;
  logic [DELAY_WIDTH-1:0] middle_delay_q, middle_delay_d;
  logic [REP_WIDTH-1:0]   no_of_rpts_q, no_of_rpts_d;
  logic [ADDR_WIDTH-1:0]  rpt_step_q, rpt_step_d;
  logic                   done_q, done_d;

  logic [ADDR_WIDTH-1:0]  step_addr;
  logic [ADDR_WIDTH-1:0]  next_base;
  logic [ADDR_WIDTH-1:0]  next_addr;
  logic                   last_in_rpt;
  logic                   last_rpt;

  assign step_addr   = step_sign_q ? (cur_addr_q - step_val_q) : (cur_addr_q + step_val_q);
  assign next_base   = base_q + rpt_step_q;
  assign last_in_rpt = (addr_idx_q == no_of_addrs_q);
  assign last_rpt    = (rpt_idx_q == no_of_rpts_q);

  // Next-state logic: sequencing FSM, address arithmetic and field capture.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d        = state_q;
    dly_cnt_d      = dly_cnt_q;
    cur_addr_d     = cur_addr_q;
    base_d         = base_q;
    addr_out_d     = addr_out_q;
    addr_idx_d     = addr_idx_q;
    rpt_idx_d      = rpt_idx_q;
    no_of_addrs_d  = no_of_addrs_q;
    step_val_d     = step_val_q;
    step_sign_d    = step_sign_q;
    middle_delay_d = middle_delay_q;
    no_of_rpts_d   = no_of_rpts_q;
    rpt_step_d     = rpt_step_q;
    done_d         = 1'b0;
    next_addr      = step_addr;

    case (state_q)
      S_IDLE: begin
        // Abort wins over a coincident start.
        if (instr_start && !abort) begin
          no_of_addrs_d  = no_of_addrs;
          step_val_d     = step_val;
          step_sign_d    = step_sign;
          middle_delay_d = middle_delay;
          no_of_rpts_d   = no_of_rpts;
          rpt_step_d     = rpt_step;
          base_d         = start_addr;
          cur_addr_d     = start_addr;
          addr_idx_d     = '0;
          rpt_idx_d      = '0;
          if (initial_delay == '0) begin
            state_d    = S_ISSUE;
            addr_out_d = start_addr;
          end else begin
            state_d   = S_INIT_DLY;
            dly_cnt_d = initial_delay;
          end
        end
      end

      S_INIT_DLY, S_MID_DLY: begin
        if (dly_cnt_q == DELAY_WIDTH'(1)) begin
          state_d    = S_ISSUE;
          addr_out_d = cur_addr_q;
        end else begin
          dly_cnt_d = dly_cnt_q - DELAY_WIDTH'(1);
        end
      end

      S_ISSUE: begin
        if (last_in_rpt && last_rpt) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          if (last_in_rpt) begin
            next_addr  = next_base;
            base_d     = next_base;
            addr_idx_d = '0;
            rpt_idx_d  = rpt_idx_q + REP_WIDTH'(1);
          end else begin
            addr_idx_d = addr_idx_q + ADDR_WIDTH'(1);
          end
          cur_addr_d = next_addr;
          if (middle_delay_q == '0) begin
            addr_out_d = next_addr;
          end else begin
            state_d   = S_MID_DLY;
            dly_cnt_d = middle_delay_q;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Cancel discards the sequence without a done pulse; addr_out keeps its value.
    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      done_d     = 1'b0;
      addr_out_d = addr_out_q;
    end
  end

  // State registers with asynchronous clear of every counter and captured field.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q        <= S_IDLE;
      dly_cnt_q      <= '0;
      cur_addr_q     <= '0;
      base_q         <= '0;
      addr_out_q     <= '0;
      addr_idx_q     <= '0;
      rpt_idx_q      <= '0;
      no_of_addrs_q  <= '0;
      step_val_q     <= '0;
      step_sign_q    <= 1'b0;
      middle_delay_q <= '0;
      no_of_rpts_q   <= '0;
      rpt_step_q     <= '0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      dly_cnt_q      <= dly_cnt_d;
      cur_addr_q     <= cur_addr_d;
      base_q         <= base_d;
      addr_out_q     <= addr_out_d;
      addr_idx_q     <= addr_idx_d;
      rpt_idx_q      <= rpt_idx_d;
      no_of_addrs_q  <= no_of_addrs_d;
      step_val_q     <= step_val_d;
      step_sign_q    <= step_sign_d;
      middle_delay_q <= middle_delay_d;
      no_of_rpts_q   <= no_of_rpts_d;
      rpt_step_q     <= rpt_step_d;
      done_q         <= done_d;
    end
  end

  assign addr_out  = addr_out_q;
  assign addr_en   = (state_q == S_ISSUE);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign start_err = instr_start && (state_q != S_IDLE);

endmodule

// File: tb/tb_refi_addr_sequencer.sv
// Scoreboard bench for refi_addr_sequencer: expected (cycle, address) pairs
// are generated from the sequence parameters and matched against addr_en.
module tb_refi_addr_sequencer;

  localparam int AW = 6;
  localparam int DW = 6;
  localparam int RW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_start;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] no_of_addrs;
  logic [DW-1:0] initial_delay;
  logic [AW-1:0] step_val;
  logic          step_sign;
  logic [DW-1:0] middle_delay;
  logic [RW-1:0] no_of_rpts;
  logic [AW-1:0] rpt_step;
  logic          abort;
  logic [AW-1:0] addr_out;
  logic          addr_en;
  logic          busy;
  logic          done;
  logic          start_err;

  refi_addr_sequencer #(.ADDR_WIDTH(AW), .DELAY_WIDTH(DW), .REP_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .instr_start(instr_start), .start_addr(start_addr),
    .no_of_addrs(no_of_addrs), .initial_delay(initial_delay), .step_val(step_val),
    .step_sign(step_sign), .middle_delay(middle_delay), .no_of_rpts(no_of_rpts),
    .rpt_step(rpt_step), .abort(abort), .addr_out(addr_out), .addr_en(addr_en),
    .busy(busy), .done(done), .start_err(start_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t          exp_q[$];
  int            checks   = 0;
  int            failures = 0;
  int            done_cyc;
  int            last_cyc;
  logic [AW-1:0] last_addr = '0;

  task automatic set_fields(input int sa, input int n, input int idly, input int stp,
                            input bit sgn, input int mdly, input int rpts, input int rstp);
    start_addr    = AW'(sa);
    no_of_addrs   = AW'(n);
    initial_delay = DW'(idly);
    step_val      = AW'(stp);
    step_sign     = sgn;
    middle_delay  = DW'(mdly);
    no_of_rpts    = RW'(rpts);
    rpt_step      = AW'(rstp);
  endtask

  task automatic scramble_fields();
    start_addr    = AW'($urandom);
    no_of_addrs   = AW'($urandom);
    initial_delay = DW'($urandom);
    step_val      = AW'($urandom);
    step_sign     = 1'($urandom);
    middle_delay  = DW'($urandom);
    no_of_rpts    = RW'($urandom);
    rpt_step      = AW'($urandom);
  endtask

  // Reference: address k of repetition r is start + r*rpt_step +/- a*step (mod 64),
  // issued at cycle 1 + initial_delay + k*(1 + middle_delay).
  task automatic build_expect(input int sa, input int n, input int idly, input int stp,
                              input bit sgn, input int mdly, input int rpts, input int rstp);
    exp_t e;
    int   k;
    int   v;
    exp_q.delete();
    k = 0;
    for (int r = 0; r <= rpts; r++) begin
      for (int a = 0; a <= n; a++) begin
        v = sa + r * rstp + (sgn ? -(a * stp) : (a * stp));
        v = ((v % 64) + 64) % 64;
        e.cyc  = 1 + idly + k * (1 + mdly);
        e.addr = AW'(v);
        exp_q.push_back(e);
        k++;
      end
    end
    last_cyc = 1 + idly + (k - 1) * (1 + mdly);
    done_cyc = last_cyc + 1;
  endtask

  task automatic trim_expect(input int upto);
    while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc > upto) void'(exp_q.pop_back());
  endtask

  // Runs ncyc cycles from the start cycle (entered at posedge+1), matching
  // addr_en against the scoreboard and checking busy/done/start_err.
  task automatic run_cycles(input int ncyc, input int abort_at, input int collide_at,
                            input int done_at, input int busy_last, input bit done_at0);
    exp_t e;
    logic exp_en;
    logic exp_done;
    logic exp_busy;
    logic exp_err;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) scramble_fields();
      instr_start = (c == 0) || (c == collide_at);
      abort       = (c == abort_at);
      @(negedge clk);
      exp_en = (exp_q.size() > 0) && (exp_q[0].cyc == c);
      checks++;
      if (addr_en !== exp_en) begin
        failures++;
        $display("FAIL addr_en cycle %0d: got %b expected %b", c, addr_en, exp_en);
      end
      if (exp_en) begin
        e = exp_q.pop_front();
        last_addr = e.addr;
      end
      checks++;
      if (addr_out !== last_addr) begin
        failures++;
        $display("FAIL addr_out cycle %0d: got %0d expected %0d", c, addr_out, last_addr);
      end
      exp_busy = (c >= 1) && (c <= busy_last);
      checks++;
      if (busy !== exp_busy) begin
        failures++;
        $display("FAIL busy cycle %0d: got %b expected %b", c, busy, exp_busy);
      end
      exp_done = (c == done_at) || (c == 0 && done_at0);
      checks++;
      if (done !== exp_done) begin
        failures++;
        $display("FAIL done cycle %0d: got %b expected %b", c, done, exp_done);
      end
      exp_err = (c == collide_at) && (c >= 1) && (c <= busy_last);
      checks++;
      if (start_err !== exp_err) begin
        failures++;
        $display("FAIL start_err cycle %0d: got %b expected %b", c, start_err, exp_err);
      end
      @(posedge clk);
      #1;
    end
    instr_start = 1'b0;
    abort       = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    instr_start = 1'b0;
    abort = 1'b0;
    set_fields(0, 0, 0, 0, 1'b0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({addr_out, addr_en, busy, done, start_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", {addr_out, addr_en, busy, done, start_err});
    end
    rst = 1'b0;
    last_addr = '0;
    // No activity may appear without a start after reset release.
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (addr_en !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_idle: got en=%b busy=%b expected 0", addr_en, busy);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    build_expect(2, 3, 0, 1, 1'b0, 0, 0, 0);
    set_fields(2, 3, 0, 1, 1'b0, 0, 0, 0);
    run_cycles(done_cyc + 3, -1, -1, done_cyc, last_cyc, 1'b0);
    checks++;
    if (done_cyc != 5) begin
      failures++;
      $display("FAIL basic_done_cycle: got %0d expected 5", done_cyc);
    end
  endtask

  task automatic test_delays_repeat();
    build_expect(0, 1, 3, 2, 1'b0, 1, 1, 8);
    set_fields(0, 1, 3, 2, 1'b0, 1, 1, 8);
    run_cycles(done_cyc + 3, -1, -1, done_cyc, last_cyc, 1'b0);
  endtask

  task automatic test_wrap_negative();
    build_expect(1, 2, 0, 1, 1'b1, 0, 0, 0);
    set_fields(1, 2, 0, 1, 1'b1, 0, 0, 0);
    run_cycles(done_cyc + 3, -1, -1, done_cyc, last_cyc, 1'b0);
  endtask

  task automatic test_collision();
    build_expect(5, 2, 1, 3, 1'b0, 2, 1, 20);
    set_fields(5, 2, 1, 3, 1'b0, 2, 1, 20);
    run_cycles(done_cyc + 3, -1, 4, done_cyc, last_cyc, 1'b0);
  endtask

  task automatic test_back_to_back();
    build_expect(10, 1, 0, 4, 1'b0, 0, 0, 0);
    set_fields(10, 1, 0, 4, 1'b0, 0, 0, 0);
    run_cycles(done_cyc, -1, -1, done_cyc, last_cyc, 1'b0);
    // Next start lands in the done cycle and must be accepted.
    build_expect(30, 2, 2, 5, 1'b1, 1, 1, 3);
    set_fields(30, 2, 2, 5, 1'b1, 1, 1, 3);
    run_cycles(done_cyc + 3, -1, -1, done_cyc, last_cyc, 1'b1);
  endtask

  task automatic test_abort();
    build_expect(0, 3, 0, 1, 1'b0, 2, 0, 0);
    trim_expect(5);
    set_fields(0, 3, 0, 1, 1'b0, 2, 0, 0);
    run_cycles(16, 5, -1, -1, 5, 1'b0);
  endtask

  task automatic test_abort_start_coincide();
    set_fields(7, 1, 0, 1, 1'b0, 0, 0, 0);
    instr_start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    checks++;
    if (start_err !== 1'b0) begin
      failures++;
      $display("FAIL coincide_start_err: got %b expected 0", start_err);
    end
    @(posedge clk);
    #1;
    instr_start = 1'b0;
    abort = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (addr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL coincide_idle: got en=%b busy=%b done=%b expected 0", addr_en, busy, done);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    build_expect(0, 3, 0, 1, 1'b0, 2, 0, 0);
    trim_expect(2);
    set_fields(0, 3, 0, 1, 1'b0, 2, 0, 0);
    run_cycles(3, -1, -1, -1, 100, 1'b0);
    // Now in cycle 3, inside the middle-delay gap.
    rst = 1'b1;
    #1;
    checks++;
    if ({addr_out, addr_en, busy, done, start_err} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got %h expected 0", {addr_out, addr_en, busy, done, start_err});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (addr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_quiet: got en=%b busy=%b done=%b expected 0", addr_en, busy, done);
      end
    end
    @(posedge clk);
    #1;
    last_addr = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delays_repeat();
    test_wrap_negative();
    test_collision();
    test_back_to_back();
    test_abort();
    test_abort_start_coincide();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/refi_addr_sequencer.md
REFI_ADDR_SEQUENCER -- requirements
Module: refi_addr_sequencer

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 6, register-file address width; DELAY_WIDTH, default 6, delay field width; REP_WIDTH, default 6, repetition field width.
REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_start  in  1  one-cycle pulse; loads REFI1/REFI2 fields.
- start_addr  in  ADDR_WIDTH  first address.
- no_of_addrs  in  ADDR_WIDTH  addresses per repetition, minus one.
- initial_delay  in  DELAY_WIDTH  idle cycles before first address.
- step_val  in  ADDR_WIDTH  magnitude of per-address step.
- step_sign  in  1  0 = add step, 1 = subtract step.
- middle_delay  in  DELAY_WIDTH  idle cycles between consecutive issued addresses.
- no_of_rpts  in  REP_WIDTH  repetitions, minus one.
- rpt_step  in  ADDR_WIDTH  unsigned increment of repetition base address.
- abort  in  1  synchronous cancel.
- addr_out  out  ADDR_WIDTH  register-file address, valid when addr_en = 1.
- addr_en  out  1  address strobe to register-file port.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- start_err  out  1  one-cycle pulse: instr_start received while busy.

Function
REQ-003 SHALL implement an FSM with states IDLE, INIT_DLY, ISSUE, MID_DLY.
REQ-004 SHALL, in IDLE on instr_start=1, capture all fields into internal registers in the same edge; input fields SHALL be ignored thereafter.
REQ-005 SHALL go IDLE->ISSUE if initial_delay=0, else IDLE->INIT_DLY with a delay counter loaded to initial_delay.
REQ-006 SHALL, with start pulse in cycle 0, assert first addr_en in cycle 1+initial_delay with addr_out=start_addr.
REQ-007 SHALL hold addr_en=1 for exactly one cycle per issued address, only in ISSUE.
REQ-008 SHALL, after each issue except the final, insert exactly middle_delay cycles of addr_en=0 (MID_DLY), skipping MID_DLY when middle_delay=0 (back-to-back issue).
REQ-009 SHALL compute next address within a repetition as addr ± step_val per step_sign, modulo 2^ADDR_WIDTH (wrap, no saturation).
REQ-010 SHALL, after no_of_addrs+1 issues, set repetition base = base + rpt_step (mod 2^ADDR_WIDTH) and restart the address at the new base; the middle_delay gap SHALL also apply across the repetition boundary.
REQ-011 SHALL issue exactly (no_of_addrs+1)*(no_of_rpts+1) addresses per sequence.
REQ-012 SHALL pulse done=1 in the cycle after the final addr_en and be in IDLE in that cycle.
REQ-013 SHALL drive busy=1 from the cycle after instr_start through the cycle of the final addr_en; busy=0 in the done cycle.
REQ-014 SHALL ignore instr_start while not IDLE, pulse start_err for one cycle, and leave the running sequence unaffected.
REQ-015 SHALL, on abort=1 in any non-IDLE state, return to IDLE next edge with addr_en=0, busy=0, no done pulse.
REQ-016 SHALL give abort priority when abort and instr_start coincide in IDLE: no sequence starts, no start_err.
REQ-017 SHALL accept instr_start in the done cycle (IDLE) as a new sequence.
REQ-018 SHALL not generate addr_en when addr_out is undefined; addr_out SHALL hold its last value when addr_en=0.

Reset
REQ-019 SHALL, on rst=1, asynchronously enter IDLE and clear addr_out, addr_en, busy, done, start_err, all counters and captured fields to 0.
REQ-020 SHALL, on reset mid-sequence, discard the sequence; no done pulse follows reset release.
REQ-021 SHALL require a new instr_start after reset release before any addr_en.

Verification
REQ-022 Basic: start_addr=2, no_of_addrs=3, step 1 (+), delays 0, no_of_rpts=0, start cycle 0 -> addr_en cycles 1..4, addr 2,3,4,5; done cycle 5.
REQ-023 Delays+repeat: start_addr=0, no_of_addrs=1, step=2, initial_delay=3, middle_delay=1, no_of_rpts=1, rpt_step=8 -> addr_en cycles 4,6,8,10 with addr 0,2,8,10; done cycle 11.
REQ-024 Wrap/negative: start_addr=1, no_of_addrs=2, step=1, step_sign=1, ADDR_WIDTH=6 -> addresses 1,0,63; done one cycle after 63.
REQ-025 Collision: second instr_start during busy -> start_err pulse that cycle, original address stream unchanged.
REQ-026 Abort/reset: abort after 2nd addr_en -> IDLE next cycle, no further addr_en, done=0; repeat with rst asserted mid-MID_DLY -> all outputs 0 immediately, none until a new start.
